div_host: RTL and testbench
===========================

Name: div_host

Overview:
Initiator for the team's serial fixed-point divider, which takes a 10-bit dividend and a 3-bit divisor and returns a 20-bit 10.10 quotient. div_host accepts one request at a time from upstream logic and handles the divider's input protocol: it drives in_valid and holds the operands stable. It then waits for out_valid with a timeout and captures the quotient. It checks the result arithmetically and returns quotient plus status on a one-cycle response strobe. Zero divisors are rejected locally and never reach the divider.

Parameters:
VALID_CYCLES, 2, cycles div_in_valid is held high per operation; minimum legal value is 2.
TIMEOUT, 64, maximum cycles spent waiting for div_out_valid before the operation is abandoned.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req_valid  input  1  upstream request strobe
req_ready  output  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high
req_dividend  input  10  dividend, unsigned integer
req_divisor  input  3  divisor, unsigned integer
resp_valid  output  1  one-cycle response strobe
resp_quotient  output  20  quotient, 10.10 unsigned fixed point
resp_err  output  2  00 ok, 01 divide-by-zero, 10 timeout, 11 check failure
div_in_valid  output  1  to divider in_valid
div_in_data_1  output  10  to divider dividend
div_in_data_2  output  3  to divider divisor
div_out_valid  input  1  from divider
div_out_data  input  20  from divider quotient

Behaviour:
- Reset: rst_n is synchronous and active-low, clock clk.
  - The FSM goes to IDLE.
  - req_ready is 1.
  - resp_valid, resp_quotient, resp_err, div_in_valid, div_in_data_1 and div_in_data_2 are all 0.
  - All counters clear.
  - Reset mid-operation abandons the operation silently, with no response; div_in_valid is 0 from the cycle after the reset edge.
- All outputs are registered.
- FSM states are IDLE, DRIVE, WAIT, DRAIN and RESP.
- IDLE:
  - On accept, latch the operands into the div_in_data registers.
  - If the divisor is 0, go to RESP with err=01 and quotient=0; no div_in_valid pulse is issued.
  - Otherwise go to DRIVE.
- DRIVE:
  - div_in_valid=1 for exactly VALID_CYCLES consecutive cycles, starting the cycle after the accept.
  - Then div_in_valid=0 and the FSM moves to WAIT.
- WAIT:
  - The timeout counter increments each cycle.
  - If div_out_valid=1, capture div_out_data and go to DRAIN.
  - Else if the counter reaches TIMEOUT-1, go to RESP with err=10 and quotient=0.
  - If out_valid and the timeout occur in the same cycle, out_valid wins.
- DRAIN: stay until div_out_valid=0, which means the divider has returned to idle, then go to RESP. The divider holds out_valid high for 2 cycles.
- div_in_data_1 and div_in_data_2 stay constant from the accept until the FSM leaves DRAIN or times out. The divider latches the dividend one cycle after in_valid falls and uses the divisor combinationally throughout.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_quotient and resp_err stable in that cycle; the FSM returns to IDLE on the next cycle.
  - resp_quotient and resp_err hold their values after the strobe, until the next RESP or reset.
- Check, using D = dividend<<10 (20 bits), d = divisor and Q = the captured quotient:
  - Compute Q*d and (Q+1)*d at 24-bit width.
  - err=00 if Q*d <= D < (Q+1)*d, otherwise err=11.
  - The quotient is reported in both cases.
- req_valid outside IDLE is ignored; req_ready is low there.
- div_out_valid outside WAIT and DRAIN is ignored.
- Throughput is one operation at a time; there is no pipelining or queueing.
- Minimum latency for a zero divisor: the accept happens at edge N and resp_valid is high in the cycle after edge N+1.

Test Plan:
- Req 10/3, with the real divider attached -> DRIVE: div_in_valid high for exactly 2 cycles. Response: one resp_valid pulse, resp_quotient=0x00D55 (3413), resp_err=00.
- Req 12/3 (exact) -> resp_quotient=0x01000, resp_err=00. Back-to-back req_valid held high -> second request accepted only after RESP; req_ready stays 0 from accept through RESP.
- Req 5/0 -> div_in_valid never asserts. resp_valid in the cycle after edge N+1, resp_quotient=0, resp_err=01.
- Req 1023/1 with a behavioural divider that never asserts out_valid -> resp_err=10 after 64 WAIT cycles, resp_quotient=0; FSM back in IDLE.
- Req 10/3 with a model returning 0x00D56 -> resp_err=11, resp_quotient=0x00D56. Model returning 0x00D54 -> resp_err=11.
- rst_n low for 1 cycle during WAIT -> no resp_valid, div_in_valid=0, req_ready=1 afterwards. A following 7/7 request -> resp_quotient=0x00400, resp_err=00.

Source files
------------

// File: rtl/div_host_if.sv
// Request/response and divider-side bundles for div_host; req side is valid/ready, divider side is valid-only.
`timescale 1ns/1ps
interface div_req_if;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_dividend;
    logic [2:0]  req_divisor;
    logic        resp_valid;
    logic [19:0] resp_quotient;
    logic [1:0]  resp_err;

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, resp_valid, resp_quotient, resp_err
    );
    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, resp_valid, resp_quotient, resp_err
    );
endinterface

interface div_bus_if;
    logic        div_in_valid;
    logic [9:0]  div_in_data_1;
    logic [2:0]  div_in_data_2;
    logic        div_out_valid;
    logic [19:0] div_out_data;

    modport master (
        output div_in_valid, div_in_data_1, div_in_data_2,
        input  div_out_valid, div_out_data
    );
    modport slave (
        input  div_in_valid, div_in_data_1, div_in_data_2,
        output div_out_valid, div_out_data
    );
endinterface

// File: rtl/div_host.sv
// Single-outstanding initiator for the serial 10.10 divider; zero divisors answered locally in 2 cycles,
// otherwise VALID_CYCLES drive + divider latency + drain + 1; req_ready is low whenever an operation is in flight.
`timescale 1ns/1ps
module div_host #(
    parameter int VALID_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    div_req_if.slave  rq,
    div_bus_if.master db
);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, DRAIN, RESP} state_t;

    localparam int CMAX = (TIMEOUT > VALID_CYCLES) ? TIMEOUT : VALID_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           req_ready_q, req_ready_d;
    logic           resp_valid_q, resp_valid_d;
    logic [19:0]    resp_quotient_q, resp_quotient_d;
    logic [1:0]     resp_err_q, resp_err_d;
    logic           div_in_valid_q, div_in_valid_d;
    logic [9:0]     dividend_q, dividend_d;
    logic [2:0]     divisor_q, divisor_d;
    logic [19:0]    pend_quot_q, pend_quot_d;
    logic [1:0]     pend_err_q, pend_err_d;

    // Range check of the returned quotient: Q*d <= D < (Q+1)*d, all at 24 bits so nothing wraps.
    logic [23:0] d_full, qd_lo, qd_hi;
    logic        chk_ok;

    always_comb begin
        d_full = {4'd0, dividend_q, 10'd0};
        qd_lo  = 24'(db.div_out_data) * 24'(divisor_q);
        qd_hi  = (24'(db.div_out_data) + 24'd1) * 24'(divisor_q);
        chk_ok = (qd_lo <= d_full) && (d_full < qd_hi);
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        div_in_valid_d  = div_in_valid_q;
        dividend_d      = dividend_q;
        divisor_d       = divisor_q;
        resp_valid_d    = 1'b0;
        resp_quotient_d = resp_quotient_q;
        resp_err_d      = resp_err_q;
        pend_quot_d     = pend_quot_q;
        pend_err_d      = pend_err_q;

        case (state_q)
            IDLE: begin
                if (rq.req_valid && req_ready_q) begin
                    dividend_d = rq.req_dividend;
                    divisor_d  = rq.req_divisor;
                    cnt_d      = '0;
                    if (rq.req_divisor == 3'd0) begin
                        pend_quot_d = '0;
                        pend_err_d  = 2'b01;
                        state_d     = RESP;
                    end else begin
                        div_in_valid_d = 1'b1;
                        state_d        = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == CW'(VALID_CYCLES - 1)) begin
                    div_in_valid_d = 1'b0;
                    cnt_d          = '0;
                    state_d        = WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A result arriving on the last allowed cycle still counts.
                if (db.div_out_valid) begin
                    pend_quot_d = db.div_out_data;
                    pend_err_d  = chk_ok ? 2'b00 : 2'b11;
                    state_d     = DRAIN;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    pend_quot_d = '0;
                    pend_err_d  = 2'b10;
                    state_d     = RESP;
                end
            end
            DRAIN: begin
                if (!db.div_out_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid_d    = 1'b1;
                resp_quotient_d = pend_quot_q;
                resp_err_d      = pend_err_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_quotient_q <= '0;
            resp_err_q      <= '0;
            div_in_valid_q  <= 1'b0;
            dividend_q      <= '0;
            divisor_q       <= '0;
            pend_quot_q     <= '0;
            pend_err_q      <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_quotient_q <= resp_quotient_d;
            resp_err_q      <= resp_err_d;
            div_in_valid_q  <= div_in_valid_d;
            dividend_q      <= dividend_d;
            divisor_q       <= divisor_d;
            pend_quot_q     <= pend_quot_d;
            pend_err_q      <= pend_err_d;
        end
    end

    assign rq.req_ready     = req_ready_q;
    assign rq.resp_valid    = resp_valid_q;
    assign rq.resp_quotient = resp_quotient_q;
    assign rq.resp_err      = resp_err_q;
    assign db.div_in_valid  = div_in_valid_q;
    assign db.div_in_data_1 = dividend_q;
    assign db.div_in_data_2 = divisor_q;
endmodule

// File: tb/tb_div_host.sv
// Bench for div_host: behavioural divider with selectable faults, response monitor, scenario tasks.
`timescale 1ns/1ps
module tb_div_host;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_req_if rq();
    div_bus_if db();

    div_host #(.VALID_CYCLES(2), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rq    (rq.slave),
        .db    (db.master)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider behaviour: 0 correct, 1 never answers, 2 returns Q+1, 3 returns Q-1.
    int div_mode = 0;
    int div_lat  = 2;

    bit          prev_iv = 0;
    bit          pend = 0;
    int          cd = 0;
    int          ov_cnt = 0;
    logic [9:0]  lat_a = '0;

    int          run = 0;
    int          runs[$];
    int          acc_q[$];
    int          resp_cyc[$];
    logic [19:0] resp_q[$];
    logic [1:0]  resp_e[$];
    bit          busy = 0;
    int          ready_viol = 0;

    function automatic logic [19:0] model_quot(logic [9:0] a, logic [2:0] b, int mode);
        int unsigned q;
        if (b == 3'd0) return 20'd0;
        q = (int'(a) * 1024) / int'(b);
        if (mode == 2) q = q + 1;
        if (mode == 3) q = q - 1;
        return q[19:0];
    endfunction

    // Expected response from arithmetic alone: ok iff the returned value is the true floor quotient.
    task automatic ref_op(input logic [9:0] a, input logic [2:0] b, input int mode,
                          output logic [19:0] q, output logic [1:0] e);
        int unsigned exact;
        if (b == 3'd0) begin
            q = '0; e = 2'b01;
        end else if (mode == 1) begin
            q = '0; e = 2'b10;
        end else begin
            exact = (int'(a) * 1024) / int'(b);
            q = model_quot(a, b, mode);
            e = (int'(q) == int'(exact)) ? 2'b00 : 2'b11;
        end
    endtask

    // Divider model and monitor, evaluated just after each falling edge.
    initial begin : model_mon
        db.div_out_valid = 1'b0;
        db.div_out_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pend = 0; ov_cnt = 0; prev_iv = 0;
                db.div_out_valid = 1'b0;
            end else begin
                if (ov_cnt > 0) begin
                    ov_cnt--;
                    if (ov_cnt == 0) db.div_out_valid = 1'b0;
                end else if (pend) begin
                    if (cd == div_lat) lat_a = db.div_in_data_1;
                    if (cd == 0) begin
                        db.div_out_data  = model_quot(lat_a, db.div_in_data_2, div_mode);
                        db.div_out_valid = 1'b1;
                        ov_cnt = 2;
                        pend = 0;
                    end else begin
                        cd--;
                    end
                end
                if (prev_iv && !db.div_in_valid && div_mode != 1) begin
                    pend = 1; cd = div_lat;
                end
                prev_iv = db.div_in_valid;
            end
            if (db.div_in_valid) run++;
            else if (run != 0) begin runs.push_back(run); run = 0; end
            if (rq.resp_valid) begin
                resp_cyc.push_back(cyc);
                resp_q.push_back(rq.resp_quotient);
                resp_e.push_back(rq.resp_err);
            end
            if (!rst_n) busy = 0;
            else begin
                if (busy && rq.req_ready && !rq.resp_valid) ready_viol++;
                if (rq.resp_valid) busy = 0;
                if (rq.req_valid && rq.req_ready) begin
                    busy = 1;
                    acc_q.push_back(cyc + 1);
                end
            end
        end
    end

    task automatic clear_q();
        runs.delete(); acc_q.delete(); resp_cyc.delete(); resp_q.delete(); resp_e.delete();
    endtask

    task automatic run_op(input logic [9:0] a, input logic [2:0] b, output bit got,
                          output logic [19:0] q, output logic [1:0] e, output int acc, output int rc);
        clear_q();
        got = 0; q = '0; e = '0; acc = -1000; rc = -1;
        @(negedge clk);
        rq.req_valid = 1'b1; rq.req_dividend = a; rq.req_divisor = b;
        for (int i = 0; i < 50; i++) begin
            #3;
            if (acc_q.size() > 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        rq.req_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #3;
            if (resp_cyc.size() > 0) break;
            @(negedge clk);
        end
        if (acc_q.size() > 0) acc = acc_q[0];
        if (resp_cyc.size() > 0) begin
            got = 1; q = resp_q[0]; e = resp_e[0]; rc = resp_cyc[0];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        n_vec++;
        if (rq.req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_req_ready got %b want 1", rq.req_ready);
        end
        n_vec++;
        if ({rq.resp_valid, rq.resp_quotient, rq.resp_err, db.div_in_valid, db.div_in_data_1, db.div_in_data_2} !== 37'd0) begin
            n_err++; $display("FAIL reset_outputs got v=%b q=%h e=%b iv=%b d1=%h d2=%h want all 0",
                rq.resp_valid, rq.resp_quotient, rq.resp_err, db.div_in_valid, db.div_in_data_1, db.div_in_data_2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit got; logic [19:0] q; logic [1:0] e; int acc, rc, r0;
        div_mode = 0; div_lat = 2;
        run_op(10'd10, 3'd3, got, q, e, acc, rc);
        r0 = (runs.size() > 0) ? runs[0] : 0;
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL basic_resp got=%b want 1", got); end
        n_vec++; if (q !== 20'h00D55) begin n_err++; $display("FAIL basic_quot got %h want 00d55", q); end
        n_vec++; if (e !== 2'b00) begin n_err++; $display("FAIL basic_err got %b want 00", e); end
        n_vec++; if (runs.size() != 1 || r0 != 2) begin
            n_err++; $display("FAIL basic_in_valid runs=%0d len=%0d want 1 run of 2", runs.size(), r0);
        end
        repeat (3) @(negedge clk);
        #3;
        n_vec++; if (resp_cyc.size() != 1 || rq.resp_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_pulse count=%0d valid=%b want 1 and 0", resp_cyc.size(), rq.resp_valid);
        end
        n_vec++; if (rq.resp_quotient !== 20'h00D55) begin
            n_err++; $display("FAIL basic_hold got %h want 00d55", rq.resp_quotient);
        end
    endtask

    task automatic test_exact_back_to_back();
        int a2, r1;
        div_mode = 0; div_lat = 3;
        clear_q();
        ready_viol = 0;
        @(negedge clk);
        rq.req_valid = 1'b1; rq.req_dividend = 10'd12; rq.req_divisor = 3'd3;
        for (int i = 0; i < 200; i++) begin
            #3;
            if (acc_q.size() >= 2) break;
            @(negedge clk);
        end
        @(negedge clk);
        rq.req_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #3;
            if (resp_cyc.size() >= 2) break;
            @(negedge clk);
        end
        a2 = (acc_q.size() >= 2) ? acc_q[1] : -1;
        r1 = (resp_cyc.size() >= 1) ? resp_cyc[0] : 1000000;
        n_vec++; if (resp_cyc.size() != 2) begin n_err++; $display("FAIL b2b_count got %0d want 2", resp_cyc.size()); end
        n_vec++; if (a2 <= r1) begin n_err++; $display("FAIL b2b_order second accept %0d first resp %0d want accept later", a2, r1); end
        for (int i = 0; i < resp_q.size(); i++) begin
            n_vec++;
            if (resp_q[i] !== 20'h01000 || resp_e[i] !== 2'b00) begin
                n_err++; $display("FAIL b2b_result%0d got q=%h e=%b want 01000/00", i, resp_q[i], resp_e[i]);
            end
        end
        n_vec++; if (ready_viol != 0) begin n_err++; $display("FAIL b2b_ready_busy got %0d cycles ready while busy want 0", ready_viol); end
    endtask

    task automatic test_zero_div();
        bit got; logic [19:0] q; logic [1:0] e; int acc, rc;
        run_op(10'd5, 3'd0, got, q, e, acc, rc);
        n_vec++; if (got !== 1'b1 || q !== 20'd0 || e !== 2'b01) begin
            n_err++; $display("FAIL zero_result got=%b q=%h e=%b want 1/0/01", got, q, e);
        end
        n_vec++; if (rc - acc != 1) begin n_err++; $display("FAIL zero_latency got %0d want 1", rc - acc); end
        n_vec++; if (runs.size() != 0) begin n_err++; $display("FAIL zero_in_valid got %0d runs want 0", runs.size()); end
    endtask

    task automatic test_timeout();
        bit got; logic [19:0] q; logic [1:0] e; int acc, rc;
        div_mode = 1;
        run_op(10'd1023, 3'd1, got, q, e, acc, rc);
        div_mode = 0;
        n_vec++; if (got !== 1'b1 || q !== 20'd0 || e !== 2'b10) begin
            n_err++; $display("FAIL timeout_result got=%b q=%h e=%b want 1/0/10", got, q, e);
        end
        n_vec++; if (rc - acc != 2 + 64 + 1) begin n_err++; $display("FAIL timeout_latency got %0d want 67", rc - acc); end
        repeat (2) @(negedge clk);
        #3;
        n_vec++; if (rq.req_ready !== 1'b1) begin n_err++; $display("FAIL timeout_idle ready=%b want 1", rq.req_ready); end
    endtask

    task automatic test_bad_quotient();
        bit got; logic [19:0] q; logic [1:0] e; int acc, rc;
        div_mode = 2;
        run_op(10'd10, 3'd3, got, q, e, acc, rc);
        n_vec++; if (q !== 20'h00D56 || e !== 2'b11) begin
            n_err++; $display("FAIL badq_high got q=%h e=%b want 00d56/11", q, e);
        end
        div_mode = 3;
        run_op(10'd10, 3'd3, got, q, e, acc, rc);
        n_vec++; if (q !== 20'h00D54 || e !== 2'b11) begin
            n_err++; $display("FAIL badq_low got q=%h e=%b want 00d54/11", q, e);
        end
        div_mode = 0;
    endtask

    task automatic test_reset_mid_wait();
        bit got; logic [19:0] q; logic [1:0] e; int acc, rc;
        div_mode = 1;
        clear_q();
        @(negedge clk);
        rq.req_valid = 1'b1; rq.req_dividend = 10'd100; rq.req_divisor = 3'd3;
        for (int i = 0; i < 50; i++) begin
            #3;
            if (acc_q.size() > 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        rq.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        n_vec++; if (db.div_in_valid !== 1'b0 || rq.req_ready !== 1'b1 || rq.resp_quotient !== 20'd0) begin
            n_err++; $display("FAIL midrst_state iv=%b ready=%b q=%h want 0/1/0", db.div_in_valid, rq.req_ready, rq.resp_quotient);
        end
        repeat (80) @(negedge clk);
        #3;
        n_vec++; if (resp_cyc.size() != 0) begin n_err++; $display("FAIL midrst_silent got %0d responses want 0", resp_cyc.size()); end
        div_mode = 0;
        run_op(10'd7, 3'd7, got, q, e, acc, rc);
        n_vec++; if (got !== 1'b1 || q !== 20'h00400 || e !== 2'b00) begin
            n_err++; $display("FAIL midrst_next got=%b q=%h e=%b want 1/00400/00", got, q, e);
        end
    endtask

    task automatic test_random();
        bit got; logic [19:0] q, eq; logic [1:0] e, ee; int acc, rc, r, exp_runs, r0;
        logic [9:0] a; logic [2:0] b;
        for (int k = 0; k < 30; k++) begin
            a = 10'($urandom_range(0, 1023));
            b = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 11);
            div_mode = (r < 8) ? 0 : (r == 8) ? 1 : (r < 10) ? 2 : 3;
            div_lat = $urandom_range(1, 6);
            run_op(a, b, got, q, e, acc, rc);
            ref_op(a, b, div_mode, eq, ee);
            exp_runs = (b == 3'd0) ? 0 : 1;
            r0 = (runs.size() > 0) ? runs[0] : 2;
            n_vec++; if (got !== 1'b1 || q !== eq || e !== ee) begin
                n_err++; $display("FAIL rand%0d %0d/%0d mode%0d got=%b q=%h e=%b want q=%h e=%b",
                    k, a, b, div_mode, got, q, e, eq, ee);
            end
            n_vec++; if (runs.size() != exp_runs || r0 != 2) begin
                n_err++; $display("FAIL rand%0d_in_valid runs=%0d len=%0d want %0d of 2", k, runs.size(), r0, exp_runs);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        div_mode = 0;
    endtask

    initial begin
        rq.req_valid = 1'b0; rq.req_dividend = '0; rq.req_divisor = '0;
        test_reset();
        test_basic();
        test_exact_back_to_back();
        test_zero_div();
        test_timeout();
        test_bad_quotient();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1);
    end
endmodule
